// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   Decodes an RV32I instruction into ALU operands and an ALU op code, and
//   registers the result into the decode/execute pipeline register.
//
// Ports
//   clk               : clock, all state updates on rising edge
//   rst_n             : synchronous active-low reset
//   id_valid          : decode-stage instruction valid
//   id_instr          : RV32I instruction word
//   id_pc             : instruction address
//   id_rs1_data       : register-file rs1 value
//   id_rs2_data       : register-file rs2 value
//   ex_stall          : execute stage holds the current entry
//   ex_flush          : kill the entry loaded on this edge
//   id_ready          : combinational, equal to !ex_stall
//   ex_valid          : registered entry valid
//   ex_operand_a      : registered ALU operand A
//   ex_operand_b      : registered ALU operand B
//   ex_alu_controller : registered ALU op code
//   ex_illegal        : registered illegal-instruction flag
//                       (only when ALU_DECODE_ILLEGAL_TRAP_EN is defined)
//
// Configuration macro: ALU_DECODE_ILLEGAL_TRAP_EN
//   Defined   -> ex_illegal output present.
//   Undefined -> ex_illegal omitted; illegal instructions pass as a valid
//                ADD of zeros.

module alu_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic        ex_stall,
  input  logic        ex_flush,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [31:0] ex_operand_a,
  output logic [31:0] ex_operand_b,
  output logic [3:0]  ex_alu_controller
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
  ,
  output logic        ex_illegal
`endif
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_OPB  = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // funct3 -> ALU code; alt selects SUB/SRA for funct3 000/101.
  function automatic logic [3:0] funct3_code(input logic [2:0] f3, input logic alt);
    logic [3:0] code;
    case (f3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];
  assign funct7 = id_instr[31:25];
  assign imm_i  = {{20{id_instr[31]}}, id_instr[31:20]};
  assign imm_s  = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_b  = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                   id_instr[30:25], id_instr[11:8], 1'b0};
  assign imm_u  = {id_instr[31:12], 12'b0};
  assign shamt  = {27'b0, id_instr[24:20]};

  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [3:0]  dec_code;
  logic        dec_illegal;

  // Illegal encodings leave the defaults (0, 0, ADD) in place.
  always_comb begin
    dec_a       = 32'd0;
    dec_b       = 32'd0;
    dec_code    = ALU_ADD;
    dec_illegal = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'h00 ||
            (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_a    = id_rs1_data;
          dec_b    = id_rs2_data;
          dec_code = funct3_code(funct3, funct7[5]);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_IMM: begin
        if (funct3 == 3'b001) begin
          if (funct7 == 7'h00) begin
            dec_a    = id_rs1_data;
            dec_b    = shamt;
            dec_code = ALU_SLL;
          end else begin
            dec_illegal = 1'b1;
          end
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'h00 || funct7 == 7'h20) begin
            dec_a    = id_rs1_data;
            dec_b    = shamt;
            dec_code = funct3_code(funct3, id_instr[30]);
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          // No SUB-immediate: the alt bit is never used outside shifts.
          dec_a    = id_rs1_data;
          dec_b    = imm_i;
          dec_code = funct3_code(funct3, 1'b0);
        end
      end
      OP_LUI: begin
        dec_b    = imm_u;
        dec_code = ALU_OPB;
      end
      OP_AUIPC: begin
        dec_a = id_pc;
        dec_b = imm_u;
      end
      OP_JAL, OP_JALR: begin
        dec_a = id_pc;
        dec_b = 32'd4;
      end
      OP_BRANCH: begin
        dec_a = id_pc;
        dec_b = imm_b;
      end
      OP_LOAD: begin
        dec_a = id_rs1_data;
        dec_b = imm_i;
      end
      OP_STORE: begin
        dec_a = id_rs1_data;
        dec_b = imm_s;
      end
      OP_FENCE, OP_SYSTEM: begin
        // a = b = 0, ADD
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign id_ready = !ex_stall;

  // Flush wins over stall; payload simply holds on flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid          <= 1'b0;
      ex_operand_a      <= 32'd0;
      ex_operand_b      <= 32'd0;
      ex_alu_controller <= 4'd0;
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
      ex_illegal        <= 1'b0;
`endif
    end else if (ex_flush) begin
      ex_valid <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid <= id_valid;
      if (id_valid) begin
        ex_operand_a      <= dec_a;
        ex_operand_b      <= dec_b;
        ex_alu_controller <= dec_code;
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
        ex_illegal        <= dec_illegal;
`endif
      end
    end
  end

`ifndef ALU_DECODE_ILLEGAL_TRAP_EN
  // The flag only feeds the optional output.
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage
//   Directed checks of the documented decode examples plus a randomized run,
//   all compared against a behavioural model of the decode/execute register.

module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        ex_stall;
  logic        ex_flush;
  logic        id_ready;
  logic        ex_valid;
  logic [31:0] ex_operand_a;
  logic [31:0] ex_operand_b;
  logic [3:0]  ex_alu_controller;
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .id_valid          (id_valid),
    .id_instr          (id_instr),
    .id_pc             (id_pc),
    .id_rs1_data       (id_rs1_data),
    .id_rs2_data       (id_rs2_data),
    .ex_stall          (ex_stall),
    .ex_flush          (ex_flush),
    .id_ready          (id_ready),
    .ex_valid          (ex_valid),
    .ex_operand_a      (ex_operand_a),
    .ex_operand_b      (ex_operand_b),
    .ex_alu_controller (ex_alu_controller)
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
    ,
    .ex_illegal        (ex_illegal)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Model of the registered stage.
  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [3:0]  m_code;
  logic        m_ill;
  logic        m_known;   // payload is defined (cleared by a flush)

  // Reference decoder: legality first, then operands from field arithmetic.
  // Returns {illegal, code, a, b}.
  function automatic logic [68:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                             input logic [31:0] r1, input logic [31:0] r2);
    logic [3:0]  base [8];
    logic [6:0]  op;
    int          f3;
    int          f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic        ill;
    logic signed [11:0] imm12;
    logic signed [12:0] imm13;
    base = '{4'd0, 4'd5, 4'd7, 4'd8, 4'd4, 4'd6, 4'd3, 4'd2};
    op  = ins[6:0];
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    a   = 0;
    b   = 0;
    c   = 0;
    ill = 0;
    case (op)
      7'h33: begin
        if (f7 == 0) begin
          a = r1; b = r2; c = base[f3];
        end else if (f7 == 32 && (f3 == 0 || f3 == 5)) begin
          a = r1; b = r2; c = (f3 == 0) ? 4'd1 : 4'd9;
        end else ill = 1;
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          if (f7 == 0 || (f3 == 5 && f7 == 32)) begin
            a = r1;
            b = 32'(ins[24:20]);
            c = (f7 == 32) ? 4'd9 : base[f3];
          end else ill = 1;
        end else begin
          imm12 = ins[31:20];
          a = r1; b = 32'(imm12); c = base[f3];
        end
      end
      7'h37: begin b = ins & 32'hFFFFF000; c = 4'd15; end
      7'h17: begin a = pc; b = ins & 32'hFFFFF000; end
      7'h6F, 7'h67: begin a = pc; b = 4; end
      7'h63: begin
        imm13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        a = pc; b = 32'(imm13);
      end
      7'h03: begin imm12 = ins[31:20]; a = r1; b = 32'(imm12); end
      7'h23: begin imm12 = {ins[31:25], ins[11:7]}; a = r1; b = 32'(imm12); end
      7'h0F, 7'h73: ;
      default: ill = 1;
    endcase
    if (ill) begin a = 0; b = 0; c = 0; end
    return {ill, c, a, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic st, input logic fl);
    id_valid    = v;
    id_instr    = ins;
    id_rs1_data = r1;
    id_rs2_data = r2;
    ex_stall    = st;
    ex_flush    = fl;
  endtask

  // One clock: update the model from the inputs seen at the edge, then
  // compare every output 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_a = 0; m_b = 0; m_code = 0; m_ill = 0; m_known = 1;
    end else if (ex_flush) begin
      m_valid = 0; m_known = 0;
    end else if (!ex_stall) begin
      m_valid = id_valid;
      if (id_valid) begin
        {m_ill, m_code, m_a, m_b} = ref_decode(id_instr, id_pc, id_rs1_data, id_rs2_data);
        m_known = 1;
      end
    end
    #1;
    txn++;
    $display("txn %0d rst_n=%0b v=%0b instr=%08h st=%0b fl=%0b -> ex_valid=%0b a=%08h b=%08h code=%0d",
             txn, rst_n, id_valid, id_instr, ex_stall, ex_flush,
             ex_valid, ex_operand_a, ex_operand_b, ex_alu_controller);
    chk("id_ready", 32'(id_ready), 32'(!ex_stall));
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    if (m_known) begin
      chk("operand_a", ex_operand_a, m_a);
      chk("operand_b", ex_operand_b, m_b);
      chk("alu_code", 32'(ex_alu_controller), 32'(m_code));
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
      chk("illegal", 32'(ex_illegal), 32'(m_ill));
`endif
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] ins;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0F, 7'h73, 7'h7F};
    ins = $urandom;
    if ($urandom_range(0, 9) != 0) begin
      ins[6:0] = ops[$urandom_range(0, 11)];
      case ($urandom_range(0, 2))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
    end
    return ins;
  endfunction

  initial begin
    m_valid = 0; m_a = 0; m_b = 0; m_code = 0; m_ill = 0; m_known = 0;
    id_pc = 32'h0000_1000;

    // Reset, also with stall and flush active.
    rst_n = 0;
    drive(1, 32'hFFF10093, 5, 7, 0, 0);
    step();
    drive(1, 32'h40208033, 10, 3, 1, 1);
    step();
    chk("reset_valid", 32'(ex_valid), 0);
    chk("reset_a", ex_operand_a, 0);
    chk("reset_b", ex_operand_b, 0);
    chk("reset_code", 32'(ex_alu_controller), 0);
    chk("reset_id_ready", 32'(id_ready), 0);
    rst_n = 1;

    // ADDI
    drive(1, 32'hFFF10093, 5, 0, 0, 0);
    step();
    chk("addi_valid", 32'(ex_valid), 1);
    chk("addi_a", ex_operand_a, 32'h5);
    chk("addi_b", ex_operand_b, 32'hFFFFFFFF);
    chk("addi_code", 32'(ex_alu_controller), 0);

    // SUB
    drive(1, 32'h40208033, 10, 3, 0, 0);
    step();
    chk("sub_a", ex_operand_a, 10);
    chk("sub_b", ex_operand_b, 3);
    chk("sub_code", 32'(ex_alu_controller), 1);

    // LUI then SRAI
    drive(1, 32'h12345037, 99, 0, 0, 0);
    step();
    chk("lui_a", ex_operand_a, 0);
    chk("lui_b", ex_operand_b, 32'h12345000);
    chk("lui_code", 32'(ex_alu_controller), 15);
    drive(1, 32'h4040D093, 32'h80000000, 0, 0, 0);
    step();
    chk("srai_b", ex_operand_b, 4);
    chk("srai_code", 32'(ex_alu_controller), 9);

    // Stall holds for 3 cycles, then flush under stall clears valid.
    drive(1, 32'hFFF10093, 5, 0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h40208033, 10, 3, 1, 0);
      step();
      chk("stall_ready", 32'(id_ready), 0);
      chk("stall_valid", 32'(ex_valid), 1);
      chk("stall_a", ex_operand_a, 5);
      chk("stall_b", ex_operand_b, 32'hFFFFFFFF);
      chk("stall_code", 32'(ex_alu_controller), 0);
    end
    drive(1, 32'h40208033, 10, 3, 1, 1);
    step();
    chk("flush_valid", 32'(ex_valid), 0);

    // Reset mid-stream.
    drive(1, 32'hFFF10093, 5, 0, 0, 0);
    step();
    chk("mid_valid_before", 32'(ex_valid), 1);
    rst_n = 0;
    drive(1, 32'h40208033, 10, 3, 0, 0);
    step();
    rst_n = 1;
    chk("mid_reset_valid", 32'(ex_valid), 0);
    chk("mid_reset_a", ex_operand_a, 0);
    chk("mid_reset_b", ex_operand_b, 0);
    chk("mid_reset_code", 32'(ex_alu_controller), 0);

    // Illegal instruction.
    drive(1, 32'hFFFFFFFF, 7, 9, 0, 0);
    step();
    chk("illegal_valid", 32'(ex_valid), 1);
    chk("illegal_a", ex_operand_a, 0);
    chk("illegal_b", ex_operand_b, 0);
    chk("illegal_code", 32'(ex_alu_controller), 0);
`ifdef ALU_DECODE_ILLEGAL_TRAP_EN
    chk("illegal_flag", 32'(ex_illegal), 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      id_pc = $urandom & 32'hFFFF_FFFC;
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
